// File: rtl/flex_frame_sr_pkg.sv
// Shared constants and helpers for the flexible serial frame receiver.
package flex_frame_sr_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // A parity-checked frame carries one extra bit after the data bits.
    function automatic int frame_len(input int num_bits, input int parity_mode);
        return (parity_mode == PARITY_NONE) ? num_bits : num_bits + 1;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter that wraps to zero on the increment that reaches rollover_val.
// rollover_flag is combinational and marks the accept that completes a wrap.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count_q + WIDTH'(1);

    // Next count: clear wins, otherwise increment and wrap at rollover_val.
    always_comb begin
        count_d       = count_q;
        rollover_flag = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_inc == rollover_val) begin
                count_d       = '0;
                rollover_flag = 1'b1;
            end else begin
                count_d = count_inc;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/flex_frame_sr.sv
// Serial-to-parallel frame receiver with optional parity bit, a
// data_ready/data_read handshake and a sticky overrun flag.
import flex_frame_sr_pkg::*;

module flex_frame_sr #(
    parameter int NUM_BITS    = 8,
    parameter int SHIFT_MSB   = 0,
    parameter int PARITY_MODE = 0
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            clear,
    input  logic                            shift_enable,
    input  logic                            serial_in,
    input  logic                            data_read,
    output logic [NUM_BITS-1:0]             rcv_data,
    output logic                            data_ready,
    output logic                            frame_done,
    output logic                            parity_error,
    output logic                            overrun_error,
    output logic [$clog2(NUM_BITS+2)-1:0]   bit_count
);

    localparam int             CW          = $clog2(NUM_BITS + 2);
    localparam int             FRAME_LEN   = frame_len(NUM_BITS, PARITY_MODE);
    localparam logic [CW-1:0]  FRAME_LEN_C = CW'(FRAME_LEN);
    localparam logic [CW-1:0]  NUM_BITS_C  = CW'(NUM_BITS);

    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] rcv_data_q, rcv_data_d;
    logic                data_ready_q, data_ready_d;
    logic                frame_done_q, frame_done_d;
    logic                parity_error_q, parity_error_d;
    logic                overrun_error_q, overrun_error_d;

    logic [CW-1:0]       count_w;
    logic                frame_complete;
    logic                accept;
    logic                data_bit;
    logic                parity_sum;
    logic                read_ack;
    logic [NUM_BITS-1:0] shifted;

    assign accept     = shift_enable & ~clear;
    // Accepted bits 1..NUM_BITS are data; anything past that is the parity bit.
    assign data_bit   = accept & (count_w < NUM_BITS_C);
    assign parity_sum = (^shift_q) ^ serial_in;
    assign read_ack   = data_read & data_ready_q;

    flex_counter #(
        .WIDTH (CW)
    ) u_bit_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .count_enable  (shift_enable),
        .rollover_val  (FRAME_LEN_C),
        .count_out     (count_w),
        .rollover_flag (frame_complete)
    );

    // Register contents after shifting serial_in in the configured direction.
    always_comb begin
        shifted = shift_q;
        if (SHIFT_MSB == 0) begin
            shifted = {serial_in, shift_q[NUM_BITS-1:1]};
        end else begin
            shifted = {shift_q[NUM_BITS-2:0], serial_in};
        end
    end

    // Shift register, frame capture, parity check and handshake/overrun.
    always_comb begin
        shift_d         = shift_q;
        rcv_data_d      = rcv_data_q;
        data_ready_d    = data_ready_q;
        frame_done_d    = 1'b0;
        parity_error_d  = parity_error_q;
        overrun_error_d = overrun_error_q;

        if (clear) begin
            shift_d = '1;
        end else if (data_bit) begin
            shift_d = shifted;
        end

        if (frame_complete) begin
            // With parity off the completing bit is a data bit, so capture
            // the post-shift value; with parity on shift_d equals shift_q.
            rcv_data_d   = shift_d;
            data_ready_d = 1'b1;
            frame_done_d = 1'b1;
            case (PARITY_MODE)
                PARITY_EVEN: parity_error_d = parity_sum;
                PARITY_ODD:  parity_error_d = ~parity_sum;
                default:     parity_error_d = 1'b0;
            endcase
            if (data_ready_q && !data_read) begin
                overrun_error_d = 1'b1;
            end else if (read_ack) begin
                overrun_error_d = 1'b0;
            end
        end else if (read_ack) begin
            data_ready_d    = 1'b0;
            overrun_error_d = 1'b0;
        end
    end

    // State registers; reset loads the shift and output registers with ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q         <= '1;
            rcv_data_q      <= '1;
            data_ready_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            shift_q         <= shift_d;
            rcv_data_q      <= rcv_data_d;
            data_ready_q    <= data_ready_d;
            frame_done_q    <= frame_done_d;
            parity_error_q  <= parity_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign rcv_data      = rcv_data_q;
    assign data_ready    = data_ready_q;
    assign frame_done    = frame_done_q;
    assign parity_error  = parity_error_q;
    assign overrun_error = overrun_error_q;
    assign bit_count     = count_w;

endmodule
